// File: rtl/neuro_arith_pkg.sv
// Shared arithmetic definitions for the neuro_skin multiply/divide path.
// Width defaults, the common state encoding and the product select helper.
package neuro_arith_pkg;

  localparam int A_W_DEF = 28;
  localparam int B_W_DEF = 20;
  localparam int P_W_DEF = 28;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    END  = 2'b11
  } arith_state_t;

  // True when the output must be forced to all-ones instead of the truncated value.
  function automatic logic sat_select(input logic ovf, input logic saturate);
    return ovf & saturate;
  endfunction

endpackage

// File: rtl/mult_seq_step.sv
// One shift-add stage: conditionally adds the aligned multiplicand.
// Purely combinational so it can be replicated in a pipelined variant.
module mult_seq_step #(
  parameter int W = 48
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] addend,
  input  logic         bit_en,
  output logic [W-1:0] acc_next
);

  // Add the partial product only when the current multiplier bit is set.
  always_comb begin
    if (bit_en) begin
      acc_next = acc + addend;
    end else begin
      acc_next = acc;
    end
  end

endmodule

// File: rtl/mult_seq_28_20.sv
// Sequential shift-add multiplier, one multiplier bit per clock.
// Inverse of the successive-approximation divider; same start/pv handshake.
module mult_seq_28_20
  import neuro_arith_pkg::*;
#(
  parameter int A_W      = A_W_DEF,
  parameter int B_W      = B_W_DEF,
  parameter int P_W      = P_W_DEF,
  parameter bit SATURATE = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic [P_W-1:0] product,
  output logic           ovf,
  output logic           pv,
  output logic           busy
);

  localparam int AB_W  = A_W + B_W;
  localparam int CNT_W = (B_W > 1) ? $clog2(B_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(B_W - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  arith_state_t    state;
  arith_state_t    next_state;
  logic [AB_W-1:0] a_sh;      // multiplicand, pre-aligned to the current bit weight
  logic [B_W-1:0]  b_reg;     // multiplier, consumed LSB first
  logic [AB_W-1:0] acc;       // full-width accumulator, cannot overflow
  logic [CNT_W-1:0] cnt;
  logic [AB_W-1:0] acc_next;
  logic [AB_W-1:0] acc_hi;
  logic            ovf_full;
  logic [P_W-1:0]  product_next;

  mult_seq_step #(.W(AB_W)) u_step (
    .acc      (acc),
    .addend   (a_sh),
    .bit_en   (b_reg[0]),
    .acc_next (acc_next)
  );

  // Overflow detection and saturate/truncate select on the finished accumulator.
  always_comb begin
    acc_hi   = acc >> P_W;
    ovf_full = |acc_hi;
    if (sat_select(ovf_full, SATURATE)) begin
      product_next = {P_W{1'b1}};
    end else begin
      product_next = acc[P_W-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: exactly B_W MUL edges, then a single END edge.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = MUL;
        end else begin
          next_state = IDLE;
        end
      end
      MUL: begin
        if (cnt == CNT_ZERO) begin
          next_state = END;
        end else begin
          next_state = MUL;
        end
      end
      END:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode: busy covers the MUL and END states only.
  always_comb begin
    busy = 1'b0;
    case (state)
      MUL:     busy = 1'b1;
      END:     busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Datapath and registered results; pv defaults low and pulses at END.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= {AB_W{1'b0}};
      b_reg   <= {B_W{1'b0}};
      acc     <= {AB_W{1'b0}};
      cnt     <= CNT_ZERO;
      product <= {P_W{1'b0}};
      ovf     <= 1'b0;
      pv      <= 1'b0;
    end else begin
      pv <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= {{B_W{1'b0}}, a};
            b_reg <= b;
            acc   <= {AB_W{1'b0}};
            cnt   <= CNT_LAST;
          end
        end
        MUL: begin
          acc   <= acc_next;
          a_sh  <= a_sh << 1;
          b_reg <= b_reg >> 1;
          if (cnt != CNT_ZERO) begin
            cnt <= cnt - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        END: begin
          ovf     <= ovf_full;
          product <= product_next;
          pv      <= 1'b1;
        end
        default: begin
          pv <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_28_20.sv
// Scoreboard bench for mult_seq_28_20: a saturating and a truncating instance
// share stimulus; expected results are computed with plain 64-bit arithmetic.
module tb_mult_seq_28_20;

  localparam int LAT = 21;   // edges from accept to the pv edge
  localparam int GAP = 22;   // accept-to-accept spacing for back-to-back ops

  typedef struct {
    logic [27:0] p;
    logic        o;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [27:0] a;
  logic [19:0] b;
  logic [27:0] product_sat, product_trn;
  logic        ovf_sat, ovf_trn, pv_sat, pv_trn, busy_sat, busy_trn;

  int   checks;
  int   errors;
  int   cyc;
  int   next_free;
  int   op_e;
  exp_t q_sat[$];
  exp_t q_trn[$];

  mult_seq_28_20 #(.SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .product(product_sat), .ovf(ovf_sat), .pv(pv_sat), .busy(busy_sat)
  );

  mult_seq_28_20 #(.SATURATE(1'b0)) dut_trn (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .product(product_trn), .ovf(ovf_trn), .pv(pv_trn), .busy(busy_trn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check_one(input string nm, input bit sat, input logic pvv,
                           input logic [27:0] pr, input logic ov, input logic bz);
    exp_t f;
    bit   have;
    bit   pv_exp;
    bit   busy_exp;
    have = 1'b0;
    if (sat && q_sat.size() > 0) begin
      f = q_sat[0]; have = 1'b1;
    end else if (!sat && q_trn.size() > 0) begin
      f = q_trn[0]; have = 1'b1;
    end
    pv_exp   = have && (f.cyc == cyc);
    busy_exp = (op_e >= 0) && (cyc >= op_e) && (cyc < op_e + LAT);
    checks++;
    if (pvv !== pv_exp) begin
      errors++;
      $display("FAIL %s pv cyc=%0d got=%b exp=%b", nm, cyc, pvv, pv_exp);
    end
    checks++;
    if (bz !== busy_exp) begin
      errors++;
      $display("FAIL %s busy cyc=%0d got=%b exp=%b", nm, cyc, bz, busy_exp);
    end
    if (pv_exp) begin
      checks++;
      if (pr !== f.p) begin
        errors++;
        $display("FAIL %s product cyc=%0d got=%h exp=%h", nm, cyc, pr, f.p);
      end
      checks++;
      if (ov !== f.o) begin
        errors++;
        $display("FAIL %s ovf cyc=%0d got=%b exp=%b", nm, cyc, ov, f.o);
      end
    end
    if (have && cyc >= f.cyc) begin
      if (sat) void'(q_sat.pop_front());
      else     void'(q_trn.pop_front());
    end
  endtask

  // Monitor: compares both instances against the scoreboard every cycle.
  always @(negedge clk) begin
    check_one("sat", 1'b1, pv_sat, product_sat, ovf_sat, busy_sat);
    check_one("trn", 1'b0, pv_trn, product_trn, ovf_trn, busy_trn);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  // Drive one start pulse; the model decides whether the block accepts it.
  task automatic issue(input logic [27:0] av, input logic [19:0] bv);
    logic [63:0] full;
    exp_t        es, et;
    int          e;
    start = 1'b1;
    a     = av;
    b     = bv;
    e     = cyc + 1;
    if (e >= next_free) begin
      full   = {36'd0, av} * {44'd0, bv};
      es.o   = (full >> 28) != 64'd0;
      et.o   = es.o;
      es.p   = es.o ? 28'hFFFFFFF : full[27:0];
      et.p   = full[27:0];
      es.cyc = e + LAT;
      et.cyc = e + LAT;
      q_sat.push_back(es);
      q_trn.push_back(et);
      next_free = e + GAP;
      op_e      = e;
    end
    idle(1);
    start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_sat.size() > 0 || q_trn.size() > 0) && n < 100) begin
      idle(1);
      n++;
    end
    checks++;
    if (q_sat.size() > 0 || q_trn.size() > 0) begin
      errors++;
      $display("FAIL drain timeout pending_sat=%0d pending_trn=%0d", q_sat.size(), q_trn.size());
      q_sat.delete();
      q_trn.delete();
    end
  endtask

  task automatic check_zero(input string nm);
    checks++;
    if ({product_sat, ovf_sat, pv_sat, busy_sat, product_trn, ovf_trn, pv_trn, busy_trn} !== 60'd0) begin
      errors++;
      $display("FAIL %s outputs got sat=%h/%b/%b/%b trn=%h/%b/%b/%b exp all zero", nm,
               product_sat, ovf_sat, pv_sat, busy_sat, product_trn, ovf_trn, pv_trn, busy_trn);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q_sat.delete();
    q_trn.delete();
    next_free = 0;
    op_e      = -1;
  endtask

  logic [27:0] ra;
  logic [19:0] rb;
  logic [63:0] dividend, divisor, quotient, prod64;

  initial begin
    checks = 0; errors = 0; cyc = 0;
    start = 1'b0; a = 28'd0; b = 20'd0;
    do_reset();
    #1;
    check_zero("reset");
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Basic product and fixed latency.
    issue(28'd1000, 20'd300);
    drain();

    // Maximum operands: saturation vs truncation.
    issue(28'hFFFFFFF, 20'hFFFFF);
    drain();

    // Zero operands keep full latency.
    issue(28'd0, 20'd12345);
    idle(LAT);
    issue(28'd777, 20'd0);
    drain();

    // Start while busy is ignored.
    issue(28'd5, 20'd7);
    idle(4);
    issue(28'd9, 20'd9);
    drain();

    // Back-to-back: second start lands in the pv cycle.
    issue(28'd3, 20'd4);
    idle(LAT - 1);
    issue(28'd6, 20'd7);
    drain();

    // Reset mid-operation aborts without a pv.
    issue(28'd100, 20'd100);
    idle(9);
    do_reset();
    #1;
    check_zero("midop_reset");
    idle(2);
    rst_n = 1'b1;
    idle(1);
    issue(28'd2, 20'd3);
    drain();

    // Randomized traffic with gaps shorter and longer than the latency.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: begin ra = 28'($urandom()); rb = 20'($urandom()); end
        1: begin ra = 28'($urandom_range(0, 999)); rb = 20'($urandom_range(0, 999)); end
        2: begin ra = 28'hFFFFFFF; rb = 20'($urandom()); end
        default: begin ra = 28'($urandom_range(0, 1)); rb = 20'($urandom()); end
      endcase
      idle($urandom_range(0, 25));
      issue(ra, rb);
    end
    drain();

    // Round trip against the divider's quotient.
    dividend = 64'd123456789;
    divisor  = 64'd1000;
    quotient = dividend / divisor;
    issue(quotient[27:0], divisor[19:0]);
    drain();
    prod64 = {36'd0, product_sat};
    checks++;
    if (!(prod64 <= dividend && (dividend - prod64) < divisor)) begin
      errors++;
      $display("FAIL roundtrip got=%0d exp within [%0d-%0d+1, %0d]", prod64, dividend, divisor, dividend);
    end

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_seq_28_20.md
Name: mult_seq_28_20

Overview:
- Sequential shift-add multiplier: the inverse of the successive-approximation divider in the neuro_skin arithmetic path.
- Rebuilds a DIVIDEND_W-wide value from a QUOTIENT_W-wide quotient and a DIVISOR_W-wide divisor.
- Processes one multiplier bit per clock and uses no DSP/IP core.
- Uses the same start/valid pulse handshake as the divider, so the two blocks can be chained for round-trip checks and rescaling.

Parameters:
- A_W, 28, multiplicand width (quotient side).
- B_W, 20, multiplier width (divisor side); sets latency.
- P_W, 28, output product width (dividend side), P_W <= A_W+B_W.
- SATURATE, 1, 1 = clamp product to all-ones on overflow; 0 = truncate to low P_W bits.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- a  in  A_W  multiplicand, captured on the accepting edge.
- b  in  B_W  multiplier, captured on the accepting edge.
- product  out  P_W  registered result; holds until the next result.
- ovf  out  1  full product >= 2^P_W; valid with pv, held with product.
- pv  out  1  product valid, one-cycle pulse.
- busy  out  1  high while an operation is in progress (state MUL or END).

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; product=0, ovf=0, pv=0, busy=0; internal accumulator, operand registers and counter cleared.
- Reset mid-operation aborts the operation. No pv is produced for it. After release the block sits in IDLE.
- States: IDLE, MUL, END.
- IDLE -> MUL on an edge where start=1:
  - a_reg<=a; b_reg<=b; acc (A_W+B_W bits)<=0; cnt<=B_W-1.
- MUL, one edge per bit:
  - if b_reg[0]: acc<=acc+(a_reg<<(B_W-1-cnt)).
  - b_reg<=b_reg>>1.
  - An equivalent right-shifting accumulator form is allowed if it gives bit-exact results.
  - cnt==0 -> END, else cnt<=cnt-1.
  - Exactly B_W edges in MUL.
- END, one edge:
  - ovf<=|acc[A_W+B_W-1:P_W].
  - product<= (ovf && SATURATE) ? all-ones : acc[P_W-1:0].
  - pv<=1; state<=IDLE.
- pv is a default-low pulse, high for exactly one cycle.
- Latency: the edge that samples start is E0. pv is high in the cycle after edge E(B_W+1) (E21 for the defaults). Latency is fixed and independent of the operand values.
- busy is high from after E0 through the cycle before pv, and is low in the pv cycle.
- start while busy=1 is ignored: no queueing, no effect on the current operation.
- start in the pv cycle is accepted (state is already IDLE), giving back-to-back operations every B_W+2 cycles.
- Arithmetic is unsigned only. The internal accumulator is full width A_W+B_W and never overflows.
- a or b equal to zero still takes the full latency and gives product=0, ovf=0.
- product and ovf change only at END and hold between results.

Decomposition:
- Shared package (neuro_arith_pkg), holding items shared with divider_28_20:
  - width constants A_W/B_W/P_W defaults.
  - state encoding localparams IDLE=2'b00, MUL=2'b01, END=2'b11.
  - helper function for the saturate/truncate select.
- Single module; no sub-module is needed.
- An optional tiny sub-module mult_seq_step (one shift-add stage, combinational) may be factored out for reuse in a future pipelined variant.

Test Plan:
- Reset then pulse start with a=1000, b=300 -> pv pulses for 1 cycle, 21 edges after accept; product=300000, ovf=0; busy high 21 cycles before pv.
- a=28'hFFFFFFF, b=20'hFFFFF, SATURATE=1 -> product=28'hFFFFFFF, ovf=1. Same operands with SATURATE=0 -> product = low 28 bits of the 48-bit product, ovf=1.
- a=0, b=12345 and a=777, b=0 -> product=0, ovf=0, latency still 21 cycles.
- Start a=5, b=7; reissue start with a=9, b=9 at cycle 5 while busy -> single pv with product=35; no second pv.
- Back-to-back: start a=3, b=4, then start a=6, b=7 in the pv cycle -> pv twice, 22 cycles apart, products 12 then 42.
- Reset mid-operation: start a=100, b=100, drop rst_n at cycle 10 -> outputs 0 immediately, no pv. Then a fresh start with a=2, b=3 -> product=6.
- Round trip with divider_28_20:
  - dividend=123456789, divisor=1000 -> quotient=123456.
  - Feed quotient and divisor into this block -> product=123456000, which is <= the dividend, and the dividend minus the product is < divisor.
